// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU and
// the LSU writeback sources with round-robin arbitration and a registered
// write stage. Optional busy scoreboard enabled by REGFILE_WB_SCOREBOARD_EN;
// without it, busy is tied low and the issue ports are ignored.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(NREGS)-1:0] alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [$clog2(NREGS)-1:0] lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic [NREGS-1:0]         busy,
    output logic                     rf_wen,
    output logic [$clog2(NREGS)-1:0] rf_wsel,
    output logic [XLEN-1:0]          rf_wdata
);

    localparam int unsigned SELW = $clog2(NREGS);

    // 1: LSU wins the next contended cycle, 0: ALU wins it
    logic            pri_lsu_q;
    logic            pri_lsu_d;
    logic            rf_wen_q;
    logic            rf_wen_d;
    logic [SELW-1:0] rf_wsel_q;
    logic [SELW-1:0] rf_wsel_d;
    logic [XLEN-1:0] rf_wdata_q;
    logic [XLEN-1:0] rf_wdata_d;

    logic            xfer_s;
    logic [SELW-1:0] win_rd_s;
    logic [XLEN-1:0] win_data_s;

    // Grant selection: ready depends only on the valids, the pointer and reset
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (rst) begin
            alu_ready = 1'b0;
            lsu_ready = 1'b0;
        end else if (alu_valid && lsu_valid) begin
            if (pri_lsu_q) begin
                lsu_ready = 1'b1;
            end else begin
                alu_ready = 1'b1;
            end
        end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
        end
    end

    // Winner mux and next-state for the pointer and the write stage
    always_comb begin
        xfer_s     = alu_ready | lsu_ready;
        win_rd_s   = {SELW{1'b0}};
        win_data_s = {XLEN{1'b0}};
        if (alu_ready) begin
            win_rd_s   = alu_rd;
            win_data_s = alu_data;
        end else begin
            win_rd_s   = lsu_rd;
            win_data_s = lsu_data;
        end

        pri_lsu_d = pri_lsu_q;
        if (alu_valid && lsu_valid && xfer_s) begin
            // Whoever won this contention yields the next one
            pri_lsu_d = alu_ready;
        end else begin
            pri_lsu_d = pri_lsu_q;
        end

        // Writes to x0 are consumed but never enabled toward the register file
        rf_wen_d   = xfer_s && (win_rd_s != {SELW{1'b0}});
        rf_wsel_d  = rf_wsel_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer_s) begin
            rf_wsel_d  = win_rd_s;
            rf_wdata_d = win_data_s;
        end else begin
            rf_wsel_d  = rf_wsel_q;
            rf_wdata_d = rf_wdata_q;
        end
    end

    // Pointer and registered write-port state
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_lsu_q  <= 1'b1;
            rf_wen_q   <= 1'b0;
            rf_wsel_q  <= {SELW{1'b0}};
            rf_wdata_q <= {XLEN{1'b0}};
        end else begin
            pri_lsu_q  <= pri_lsu_d;
            rf_wen_q   <= rf_wen_d;
            rf_wsel_q  <= rf_wsel_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_wsel  = rf_wsel_q;
    assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear on accepted writeback, then set on issue so a new producer wins
    always_comb begin
        busy_d = busy_q;
        if (xfer_s && (win_rd_s != {SELW{1'b0}})) begin
            busy_d[win_rd_s] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_valid && (issue_rd != {SELW{1'b0}})) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_issue_s;

    assign busy           = {NREGS{1'b0}};
    assign unused_issue_s = ^{issue_valid, issue_rd};
`endif

endmodule
